// File: rtl/axis_gmii_rx_len_if.sv
// AXI-Stream byte output bundle for the GMII receive framer.
//   tdata  : received byte
//   tvalid : byte valid (one beat, no back-pressure)
//   tlast  : final beat of the frame
//   tuser  : 1 = frame is bad (checked on the tlast beat)
// Handshake: a beat is transferred on every cycle with tvalid=1. There is no
// tready, so the consumer must accept every beat in the cycle it appears.
interface axis_gmii_rx_len_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/axis_gmii_rx_len.sv
// GMII receive framer with FCS check, length policing and frame statistics.
// Strips preamble/SFD, delivers payload bytes (FCS excluded) on an AXI-Stream
// byte output and flags bad frames on the tlast beat.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   gmii_rxd/dv/er      : GMII receive bus
//   clk_enable          : qualifies each GMII sample
//   cfg_rx_enable       : allows a new frame to start
//   m_axis              : AXI-Stream output (master modport)
//   start_packet        : pulse when an SFD is accepted
//   frame_len(_valid)   : beats delivered in the frame, on the tlast cycle
//   error_*             : one-cycle status pulses on the tlast cycle
//   stat_good/stat_bad  : saturating frame counters
//   dbg_state           : current FSM state
module axis_gmii_rx_len #(
  parameter int DATA_WIDTH    = 8,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int LEN_WIDTH     = 16,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] gmii_rxd,
  input  logic                  gmii_rx_dv,
  input  logic                  gmii_rx_er,
  input  logic                  clk_enable,
  input  logic                  cfg_rx_enable,
  axis_gmii_rx_len_if.master    m_axis,
  output logic                  start_packet,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  frame_len_valid,
  output logic                  error_bad_frame,
  output logic                  error_bad_fcs,
  output logic                  error_runt,
  output logic                  error_oversize,
  output logic [STAT_WIDTH-1:0] stat_good,
  output logic [STAT_WIDTH-1:0] stat_bad,
  output logic [1:0]            dbg_state
);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("axis_gmii_rx_len: DATA_WIDTH must be 8");
  end
  if (MAX_FRAME_LEN <= MIN_FRAME_LEN) begin : g_bad_frame_len
    $error("axis_gmii_rx_len: MAX_FRAME_LEN must exceed MIN_FRAME_LEN");
  end

  // Bit-reversed form of 32'h04C11DB7: the LFSR shifts right, LSB first.
  localparam logic [31:0] CRC_POLY_REV = 32'hEDB88320;
  localparam logic [LEN_WIDTH-1:0] OVERSIZE_BEATS = LEN_WIDTH'(MAX_FRAME_LEN - 4);

  typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, WAIT_LAST = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  rxd_d [0:4];
  logic                   dv_d  [0:4];
  logic                   er_d  [0:4];
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic [31:0]            crc_q, crc_d, crc_next;

  logic emit, last, user, sp, e_bad, e_fcs, e_runt, e_over;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ CRC_POLY_REV) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_next  = crc_step(crc_q, rxd_d[4]);
  assign dbg_state = state_q;

  // Delay line: when dv drops every stage is cleared at once, so the four
  // newest bytes (d0..d3) hold exactly the FCS when the frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        rxd_d[i] <= '0;
        dv_d[i]  <= 1'b0;
        er_d[i]  <= 1'b0;
      end
    end else if (clk_enable) begin
      rxd_d[0] <= gmii_rxd;
      dv_d[0]  <= gmii_rx_dv;
      er_d[0]  <= gmii_rx_er;
      for (int i = 1; i < 5; i++) begin
        rxd_d[i] <= rxd_d[i-1];
        dv_d[i]  <= dv_d[i-1] & gmii_rx_dv;
        er_d[i]  <= er_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      crc_q   <= 32'hFFFF_FFFF;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      crc_q   <= crc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    crc_d   = crc_q;
    emit    = 1'b0;
    last    = 1'b0;
    user    = 1'b0;
    sp      = 1'b0;
    e_bad   = 1'b0;
    e_fcs   = 1'b0;
    e_runt  = 1'b0;
    e_over  = 1'b0;
    if (clk_enable) begin
      case (state_q)
        IDLE: begin
          crc_d = 32'hFFFF_FFFF;
          if (dv_d[4] && !er_d[4] && rxd_d[4] == 8'hD5 && cfg_rx_enable) begin
            state_d = PAYLOAD;
            sp      = 1'b1;
            count_d = '0;
          end
        end
        PAYLOAD: begin
          emit    = 1'b1;
          count_d = count_q + LEN_WIDTH'(1);
          crc_d   = crc_next;
          if (dv_d[4] && er_d[4]) begin
            last    = 1'b1;
            user    = 1'b1;
            e_bad   = 1'b1;
            state_d = WAIT_LAST;
          end else if (!gmii_rx_dv) begin
            // End of frame: d4 is the last payload byte, d0..d3 the FCS.
            last    = 1'b1;
            state_d = IDLE;
            if (er_d[0] || er_d[1] || er_d[2] || er_d[3]) begin
              user  = 1'b1;
              e_bad = 1'b1;
            end else if ({rxd_d[0], rxd_d[1], rxd_d[2], rxd_d[3]} != ~crc_next) begin
              user  = 1'b1;
              e_bad = 1'b1;
              e_fcs = 1'b1;
            end else if ((int'(count_d) + 4) < MIN_FRAME_LEN) begin
              user   = 1'b1;
              e_bad  = 1'b1;
              e_runt = 1'b1;
            end
          end else if (count_d == OVERSIZE_BEATS) begin
            last    = 1'b1;
            user    = 1'b1;
            e_bad   = 1'b1;
            e_over  = 1'b1;
            state_d = WAIT_LAST;
          end
        end
        WAIT_LAST: begin
          if (!gmii_rx_dv) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs: pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis.tdata    <= '0;
      m_axis.tvalid   <= 1'b0;
      m_axis.tlast    <= 1'b0;
      m_axis.tuser    <= 1'b0;
      start_packet    <= 1'b0;
      frame_len       <= '0;
      frame_len_valid <= 1'b0;
      error_bad_frame <= 1'b0;
      error_bad_fcs   <= 1'b0;
      error_runt      <= 1'b0;
      error_oversize  <= 1'b0;
      stat_good       <= '0;
      stat_bad        <= '0;
    end else begin
      m_axis.tdata    <= emit ? rxd_d[4] : '0;
      m_axis.tvalid   <= emit;
      m_axis.tlast    <= last;
      m_axis.tuser    <= user;
      start_packet    <= sp;
      frame_len_valid <= last;
      error_bad_frame <= e_bad;
      error_bad_fcs   <= e_fcs;
      error_runt      <= e_runt;
      error_oversize  <= e_over;
      if (last) frame_len <= count_d;
      if (last && !user && stat_good != '1) stat_good <= stat_good + STAT_WIDTH'(1);
      if (last && user && stat_bad != '1)   stat_bad  <= stat_bad + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_gmii_rx_len.sv
// Directed bench for axis_gmii_rx_len: good, bad-FCS, runt, oversize, rx_er,
// clk_enable gating, cfg_rx_enable and mid-frame reset.
module tb_axis_gmii_rx_len;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv, gmii_rx_er, clk_enable, cfg_rx_enable;
  logic        start_packet, frame_len_valid;
  logic [15:0] frame_len;
  logic        error_bad_frame, error_bad_fcs, error_runt, error_oversize;
  logic [31:0] stat_good, stat_bad;
  logic [1:0]  dbg_state;

  axis_gmii_rx_len_if #(.DATA_WIDTH(8)) m_axis ();

  axis_gmii_rx_len dut (
    .clk(clk), .rst_n(rst_n),
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .clk_enable(clk_enable), .cfg_rx_enable(cfg_rx_enable),
    .m_axis(m_axis),
    .start_packet(start_packet),
    .frame_len(frame_len), .frame_len_valid(frame_len_valid),
    .error_bad_frame(error_bad_frame), .error_bad_fcs(error_bad_fcs),
    .error_runt(error_runt), .error_oversize(error_oversize),
    .stat_good(stat_good), .stat_bad(stat_bad),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit ce_toggle = 1'b0;

  logic [7:0] exp_q[$];

  // Monitor state, cleared before each frame
  int beats, stray, sp_cnt, b2b;
  bit saw_last, saw_wait, prev_v;
  bit m_user, m_flv, m_bad, m_fcs, m_runt, m_over;
  int m_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    beats = 0; stray = 0; sp_cnt = 0; b2b = 0;
    saw_last = 0; saw_wait = 0;
    m_user = 0; m_flv = 0; m_bad = 0; m_fcs = 0; m_runt = 0; m_over = 0; m_len = 0;
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (m_axis.tvalid) begin
      beats++;
      if (exp_q.size() != 0) check("tdata", m_axis.tdata, exp_q.pop_front());
      if (prev_v) b2b++;
      if (m_axis.tlast) begin
        saw_last = 1;
        m_user = m_axis.tuser; m_len = frame_len; m_flv = frame_len_valid;
        m_bad = error_bad_frame; m_fcs = error_bad_fcs;
        m_runt = error_runt; m_over = error_oversize;
      end
    end
    if (!(m_axis.tvalid && m_axis.tlast) &&
        (frame_len_valid || error_bad_frame || error_bad_fcs || error_runt || error_oversize))
      stray++;
    if (start_packet) sp_cnt++;
    if (dbg_state == 2'd2) saw_wait = 1;
    prev_v = m_axis.tvalid;
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Driver: one GMII sample, with an optional disabled cycle after it
  task automatic gmii(input logic [7:0] d, input logic dv, input logic er);
    gmii_rxd = d; gmii_rx_dv = dv; gmii_rx_er = er; clk_enable = 1'b1;
    @(posedge clk); #1;
    if (ce_toggle) begin
      clk_enable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Sends preamble, SFD, payload, FCS and an idle gap. Payload bytes stay
  // below 8'h80 so they can never look like an SFD.
  task automatic send_frame(input int n_pay, input int seed, input bit flip_fcs,
                            input int er_idx, input int keep, input int cfg_off_idx,
                            input int abort_idx);
    logic [7:0]  pay[$];
    logic [31:0] crc, fcs;
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < n_pay; i++) begin
      pay.push_back(8'((i * 3 + seed) & 8'h7F));
      crc = crc_upd(crc, pay[i]);
    end
    fcs = ~crc;
    if (flip_fcs) fcs[0] = ~fcs[0];
    for (int i = 0; i < keep; i++) exp_q.push_back(pay[i]);
    for (int i = 0; i < 7; i++) gmii(8'h55, 1'b1, 1'b0);
    gmii(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n_pay; i++) begin
      if (i == cfg_off_idx) cfg_rx_enable = 1'b0;
      if (i == abort_idx) begin
        rst_n = 1'b0;
        #1;
        check("rst_tvalid", m_axis.tvalid, 0);
        check("rst_tlast", m_axis.tlast, 0);
        check("rst_stat_good", stat_good, 0);
        check("rst_state", dbg_state, 0);
        check("rst_frame_len", frame_len, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      gmii(pay[i], 1'b1, i == er_idx);
    end
    for (int i = 0; i < 4; i++) gmii(fcs[8*i +: 8], 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) gmii(8'h00, 1'b0, 1'b0);
    cfg_rx_enable = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int exp_beats, input bit user,
                             input bit fcs_e, input bit runt_e, input bit over_e,
                             input int good, input int bad);
    check({tag, "_beats"}, beats, exp_beats);
    check({tag, "_tlast"}, saw_last, 1);
    check({tag, "_tuser"}, m_user, user);
    check({tag, "_frame_len"}, m_len, exp_beats);
    check({tag, "_len_valid"}, m_flv, 1);
    check({tag, "_bad_frame"}, m_bad, user);
    check({tag, "_bad_fcs"}, m_fcs, fcs_e);
    check({tag, "_runt"}, m_runt, runt_e);
    check({tag, "_oversize"}, m_over, over_e);
    check({tag, "_stray"}, stray, 0);
    check({tag, "_missing"}, exp_q.size(), 0);
    check({tag, "_start_pkt"}, sp_cnt, 1);
    check({tag, "_stat_good"}, stat_good, good);
    check({tag, "_stat_bad"}, stat_bad, bad);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0; gmii_rxd = '0; gmii_rx_dv = 0; gmii_rx_er = 0;
    clk_enable = 0; cfg_rx_enable = 1; prev_v = 0;
    clear_mon();
    #3;
    check("reset_tvalid", m_axis.tvalid, 0);
    check("reset_tuser", m_axis.tuser, 0);
    check("reset_stat_good", stat_good, 0);
    check("reset_stat_bad", stat_bad, 0);
    check("reset_state", dbg_state, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) gmii(8'h00, 1'b0, 1'b0);

    clear_mon(); send_frame(60, 1, 0, -1, 60, -1, -1);
    check_frame("good", 60, 0, 0, 0, 0, 1, 0);

    clear_mon(); send_frame(60, 5, 1, -1, 60, -1, -1);
    check_frame("bad_fcs", 60, 1, 1, 0, 0, 1, 1);

    clear_mon(); send_frame(40, 9, 0, -1, 40, -1, -1);
    check_frame("runt", 40, 1, 0, 1, 0, 1, 2);

    clear_mon(); send_frame(1600, 2, 0, -1, 1514, -1, -1);
    check_frame("oversize", 1514, 1, 0, 0, 1, 1, 3);
    check("oversize_wait_last", saw_wait, 1);

    clear_mon(); send_frame(60, 7, 0, 9, 10, -1, -1);
    check_frame("rx_er", 10, 1, 0, 0, 0, 1, 4);
    check("rx_er_wait_last", saw_wait, 1);

    clear_mon(); send_frame(60, 11, 0, -1, 60, -1, -1);
    check_frame("after_er", 60, 0, 0, 0, 0, 2, 4);

    ce_toggle = 1'b1;
    clear_mon(); send_frame(60, 1, 0, -1, 60, -1, -1);
    ce_toggle = 1'b0;
    check_frame("ce_toggle", 60, 0, 0, 0, 0, 3, 4);
    check("ce_toggle_back_to_back", b2b, 0);

    cfg_rx_enable = 1'b0;
    clear_mon(); send_frame(60, 3, 0, -1, 0, -1, -1);
    check("cfg_off_beats", beats, 0);
    check("cfg_off_start_pkt", sp_cnt, 0);
    check("cfg_off_stat_good", stat_good, 3);

    clear_mon(); send_frame(60, 4, 0, -1, 60, 5, -1);
    check_frame("cfg_drop_mid", 60, 0, 0, 0, 0, 4, 4);

    clear_mon(); send_frame(60, 6, 0, -1, 60, -1, 24);
    check("abort_no_tlast", saw_last, 0);
    check("abort_stat_bad", stat_bad, 0);

    clear_mon(); send_frame(60, 8, 0, -1, 60, -1, -1);
    check_frame("after_reset", 60, 0, 0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_gmii_rx_len.md
AXIS_GMII_RX_LEN -- requirements
Module: axis_gmii_rx_len

Interface
REQ-001 Parameter DATA_WIDTH, default 8, GMII byte width; any other value SHALL stop elaboration with an error.
REQ-002 Parameter MIN_FRAME_LEN, default 64, minimum legal frame length in bytes, destination MAC through FCS inclusive.
REQ-003 Parameter MAX_FRAME_LEN, default 1518, maximum legal frame length in bytes, FCS inclusive; SHALL be greater than MIN_FRAME_LEN.
REQ-004 Parameter LEN_WIDTH, default 16, width of the length counter.
REQ-005 Parameter STAT_WIDTH, default 32, width of the statistics counters.
REQ-006 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 gmii_rxd  in  8, gmii_rx_dv  in  1, gmii_rx_er  in  1: GMII receive bus.
REQ-009 clk_enable  in  1  qualifies every GMII sample; cfg_rx_enable  in  1  allows a new frame to start.
REQ-010 m_axis_tdata  out  8, m_axis_tvalid  out  1, m_axis_tlast  out  1, m_axis_tuser  out  1 (1 = bad frame); the output has no tready.
REQ-011 start_packet  out  1  one-cycle pulse when an SFD is accepted.
REQ-012 frame_len  out  LEN_WIDTH, frame_len_valid  out  1: payload bytes delivered (FCS excluded), valid for one cycle.
REQ-013 error_bad_frame, error_bad_fcs, error_runt, error_oversize  out  1 each: one-cycle status pulses.
REQ-014 stat_good  out  STAT_WIDTH, stat_bad  out  STAT_WIDTH: frame counters.

Function
REQ-015 A five-stage delay line d0..d4 for rxd, dv and er SHALL advance only when clk_enable=1.
- Each dv stage is ANDed with the live gmii_rx_dv.
REQ-016 The FCS engine SHALL be the codebase lfsr: 32-bit, polynomial 32'h04C11DB7, Galois form, REVERSE=1, fed from d4.
- It SHALL be preset to 32'hFFFFFFFF in IDLE.
- It SHALL be updated on every enabled PAYLOAD cycle.
REQ-017 The state machine SHALL have three states: IDLE, PAYLOAD and WAIT_LAST.
- It SHALL hold its state on any cycle with clk_enable=0.
REQ-018 IDLE -> PAYLOAD SHALL occur when dv_d4=1, er_d4=0, d4==8'hD5 and cfg_rx_enable=1.
- That cycle SHALL pulse start_packet, clear the byte counter and clear the FCS state.
REQ-019 In PAYLOAD, each enabled cycle SHALL emit d4 with tvalid=1 and increment the byte counter.
REQ-020 In PAYLOAD, if dv_d4=1 and er_d4=1, the module SHALL:
- emit the byte with tlast=1 and tuser=1;
- pulse error_bad_frame;
- go to WAIT_LAST.
REQ-021 In PAYLOAD, when gmii_rx_dv=0 the emitted byte SHALL carry tlast=1 and the state SHALL return to IDLE; d0..d3 hold the FCS.
- If any of er_d0..er_d3 is set: tuser=1 and error_bad_frame.
- Otherwise, if {d0,d1,d2,d3} != ~crc_next: tuser=1, error_bad_frame and error_bad_fcs.
- Otherwise, if count+4 < MIN_FRAME_LEN: tuser=1, error_bad_frame and error_runt.
- Otherwise: tuser=0.
REQ-022 When the emitted byte brings the count to MAX_FRAME_LEN-4 and gmii_rx_dv=1, the module SHALL:
- emit that byte with tlast=1 and tuser=1;
- pulse error_oversize and error_bad_frame;
- go to WAIT_LAST.
REQ-023 In WAIT_LAST nothing SHALL be emitted; the state SHALL return to IDLE on the first enabled cycle with gmii_rx_dv=0.
REQ-024 Outputs SHALL be registered, so there is one cycle from the state decision to tvalid.
- frame_len and frame_len_valid, the error pulses, and the stat update SHALL appear in the same cycle as tlast.
REQ-025 frame_len SHALL equal the number of beats in the frame, the tlast beat included.
REQ-026 stat_good SHALL increment on tlast with tuser=0; stat_bad SHALL increment on tlast with tuser=1.
- Both SHALL saturate at all-ones.
REQ-027 Deasserting cfg_rx_enable mid-frame SHALL NOT affect that frame.
REQ-028 Outside a frame, tvalid, tlast and tuser SHALL be 0.

Reset
REQ-029 While rst_n=0, all outputs and counters SHALL be 0 and the state SHALL be IDLE, independent of clk.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no tlast.
- After release, the module SHALL wait for a new SFD.
REQ-031 Data-path registers without reset SHALL NOT reach the outputs before the first accepted SFD.

Verification
REQ-032 Good frame: 7x 55, D5, 60 payload bytes and a correct FCS -> 60 beats, tuser=0 on tlast, frame_len=60, stat_good=1.
REQ-033 Corrupted FCS: flip bit 0 of FCS byte 0 -> tuser=1, error_bad_fcs=1, error_bad_frame=1, stat_bad=1.
REQ-034 Runt: 40 payload bytes with a good FCS -> tuser=1, error_runt=1, frame_len=40.
REQ-035 Oversize: 1600 payload bytes -> tlast on beat 1514 with tuser=1, error_oversize=1, and no further beats until dv=0.
REQ-036 er=1 on payload byte 10 -> tlast on beat 10 with tuser=1 and WAIT_LAST; the next frame is received clean.
REQ-037 clk_enable toggled 1/0 through a good frame -> same beats as REQ-032, one per enabled cycle.
REQ-038 rst_n pulsed low at beat 20 -> outputs 0 immediately; a following good frame gives stat_good=1.
